// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
// Latency: n/a (wiring only).
// Backpressure: req is held by a requester until its one-cycle ack.
// Ports:
//   p0_* / p1_*        request/ack/data signals for the CPU port and secondary master
//   mem_*              single-port DataMemory access signals
//   busy               arbiter has an access in flight
// Modports:
//   slave  - the arbiter side
//   master - the requester/memory side (testbench or top level)
interface dmem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_ack;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_ack;

   logic              mem_read_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_out;
   logic [DATA_W-1:0] mem_data_in;
   logic              busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_rdata, p0_ack,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      output p1_rdata, p1_ack,
      output mem_read_write, mem_addr, mem_data_out,
      input  mem_data_in,
      output busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_rdata, p0_ack,
      output p1_req, p1_we, p1_addr, p1_wdata,
      input  p1_rdata, p1_ack,
      input  mem_read_write, mem_addr, mem_data_out,
      output mem_data_in,
      input  busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port DataMemory (CPU port 0, loader/DMA port 1).
// Latency: req seen at edge N -> memory access in cycle N+1 -> ack (and read data) in cycle N+2.
// Backpressure: requesters hold req until their 1-cycle ack; a port is masked while completing and in its ack cycle.
// Ports: clk, rst_n (async active-low); bus (dmem_arbiter_if.slave) carrying both request ports,
//        the DataMemory access signals and busy.
// Build option: define DMEM_ARB_RR_EN for round-robin between simultaneous requests;
//        otherwise port 0 has fixed priority.
module dmem_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // Latched winning request; inputs are ignored after grant.
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_port;

   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;

`ifdef DMEM_ARB_RR_EN
   logic              r_last_grant;
`endif

   logic              w_elig0;
   logic              w_elig1;
   logic              w_load;
   logic              w_sel;
   logic              w_done;
   logic              w_in_access;

   assign w_in_access = (r_state == S_ACCESS);

   // A port is not eligible in its own ack cycle nor while its access is completing,
   // so a held req becomes a fresh request only after the ack cycle.
   assign w_elig0 = bus.p0_req & ~r_p0_ack & ~(w_in_access & (r_port == 1'b0));
   assign w_elig1 = bus.p1_req & ~r_p1_ack & ~(w_in_access & (r_port == 1'b1));

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_sel       = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_elig0 | w_elig1) begin
               w_load      = 1'b1;
               w_state_nxt = S_ACCESS;
               if (w_elig0 & w_elig1) begin
`ifdef DMEM_ARB_RR_EN
                  w_sel = ~r_last_grant;
`else
                  w_sel = 1'b0;
`endif
               end else begin
                  w_sel = w_elig1;
               end
            end
         end
         S_ACCESS: begin
            w_done = 1'b1;
            // Only the other port can follow back-to-back; the finishing one is masked.
            if (r_port ? w_elig0 : w_elig1) begin
               w_load = 1'b1;
               w_sel  = ~r_port;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_port       <= 1'b0;
         r_p0_ack     <= 1'b0;
         r_p1_ack     <= 1'b0;
         r_p0_rdata   <= '0;
         r_p1_rdata   <= '0;
`ifdef DMEM_ARB_RR_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_we         <= w_sel ? bus.p1_we    : bus.p0_we;
            r_addr       <= w_sel ? bus.p1_addr  : bus.p0_addr;
            r_wdata      <= w_sel ? bus.p1_wdata : bus.p0_wdata;
            r_port       <= w_sel;
`ifdef DMEM_ARB_RR_EN
            r_last_grant <= w_sel;
`endif
         end
         r_p0_ack <= w_done & ~r_port;
         r_p1_ack <= w_done &  r_port;
         // Writes leave the port's last read data untouched.
         if (w_done & ~r_we & ~r_port) r_p0_rdata <= bus.mem_data_in;
         if (w_done & ~r_we &  r_port) r_p1_rdata <= bus.mem_data_in;
      end
   end

   // Memory drive is gated by state so reset drops a write immediately.
   assign bus.mem_read_write = w_in_access & r_we;
   assign bus.mem_addr       = w_in_access ? r_addr  : '0;
   assign bus.mem_data_out   = w_in_access ? r_wdata : '0;
   assign bus.busy           = w_in_access;

   assign bus.p0_ack   = r_p0_ack;
   assign bus.p1_ack   = r_p1_ack;
   assign bus.p0_rdata = r_p0_rdata;
   assign bus.p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a transaction-level reference model.
// Latency: n/a.
// Backpressure: requests are held until ack, as a well-behaved master would.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst_n;

   dmem_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

   dmem_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Emulated DataMemory: combinational read, write on the clock edge.
   bit [15:0] dm [512];
   logic      ovr_en;
   logic [15:0] ovr_val;
   assign bus.mem_data_in = ovr_en ? ovr_val : dm[bus.mem_addr];
   always @(posedge clk) if (bus.mem_read_write) dm[bus.mem_addr] <= bus.mem_data_out;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: at most one transaction in flight; it completes one cycle
   // after grant, then its port gets an ack and (for reads) the memory word.
   bit          m_busy, m_port, m_we, m_last, m_win;
   logic [8:0]  m_addr;
   logic [15:0] m_wdata;
   bit [1:0]    m_ack, m_ack_new, m_req, m_elig;
   logic [15:0] m_rd [2];
   bit [15:0]   m_mem [512];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_ack = '0; m_rd[0] = '0; m_rd[1] = '0; m_last = 1'b1;
         end else begin
            m_req = {bus.p1_req, bus.p0_req};
            for (int p = 0; p < 2; p++)
               m_elig[p] = m_req[p] && !m_ack[p] && !(m_busy && (m_port == p[0]));
            m_ack_new = '0;
            if (m_busy) begin
               m_ack_new[m_port] = 1'b1;
               if (m_we) m_mem[m_addr] = m_wdata;
               else m_rd[m_port] = ovr_en ? ovr_val : m_mem[m_addr];
            end
            if (m_elig == 2'b11) m_win = RR ? ~m_last : 1'b0;
            else                 m_win = m_elig[1];
            if (m_elig != 2'b00) begin
               m_busy  = 1'b1;
               m_port  = m_win;
               m_we    = m_win ? bus.p1_we    : bus.p0_we;
               m_addr  = m_win ? bus.p1_addr  : bus.p0_addr;
               m_wdata = m_win ? bus.p1_wdata : bus.p0_wdata;
               m_last  = m_win;
            end else begin
               m_busy = 1'b0;
            end
            m_ack = m_ack_new;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("mem_read_write", 32'(bus.mem_read_write), 32'(m_busy & m_we));
         chk("mem_addr",       32'(bus.mem_addr),       32'(m_busy ? m_addr : 9'h0));
         chk("mem_data_out",   32'(bus.mem_data_out),   32'(m_busy ? m_wdata : 16'h0));
         chk("busy",           32'(bus.busy),           32'(m_busy));
         chk("p0_ack",         32'(bus.p0_ack),         32'(m_ack[0]));
         chk("p1_ack",         32'(bus.p1_ack),         32'(m_ack[1]));
         chk("p0_rdata",       32'(bus.p0_rdata),       32'(m_rd[0]));
         chk("p1_rdata",       32'(bus.p1_rdata),       32'(m_rd[1]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "time limit");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One access on one port from an idle bus; returns latency, write cycles seen,
   // read data at ack and the other port's ack at that moment.
   task automatic access(input bit port, input bit we, input logic [8:0] addr,
                         input logic [15:0] wd, output int lat, output int wcyc,
                         output logic [15:0] rd, output logic oth_ack);
      lat = -1; wcyc = 0; rd = 'x; oth_ack = 'x;
      if (port) begin
         bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd; bus.p1_req = 1'b1;
      end else begin
         bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd; bus.p0_req = 1'b1;
      end
      for (int c = 1; c <= 20; c++) begin
         step();
         if (bus.mem_read_write) wcyc++;
         if ((port ? bus.p1_ack : bus.p0_ack) == 1'b1) begin
            lat     = c;
            rd      = port ? bus.p1_rdata : bus.p0_rdata;
            oth_ack = port ? bus.p0_ack : bus.p1_ack;
            break;
         end
      end
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      step();
   endtask

   int          lat, wcyc, a0, a1, n0, n1, acks;
   logic [15:0] rd;
   logic        oth;

   initial begin
      rst_n = 1'b0;
      ovr_en = 1'b0; ovr_val = '0;
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
      step();
      chk("reset busy", 32'(bus.busy), 32'h0);
      chk("reset p0_ack", 32'(bus.p0_ack), 32'h0);
      chk("reset p1_rdata", 32'(bus.p1_rdata), 32'h0);
      #2 rst_n = 1'b1;

      // Idle bus: nothing happens for 10 cycles.
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         acks += int'(bus.p0_ack) + int'(bus.p1_ack) + int'(bus.mem_read_write);
      end
      chk("idle activity", 32'(acks), 32'h0);
      chk("idle busy", 32'(bus.busy), 32'h0);

      // Port 0 write then read back.
      access(1'b0, 1'b1, 9'h010, 16'h1234, lat, wcyc, rd, oth);
      chk("p0 write latency", 32'(lat), 32'd2);
      chk("p0 write cycles", 32'(wcyc), 32'd1);
      access(1'b0, 1'b0, 9'h010, 16'h0, lat, wcyc, rd, oth);
      chk("p0 read latency", 32'(lat), 32'd2);
      chk("p0 read data", 32'(rd), 32'h1234);

      // Port 1 read at the top address with forced memory data.
      ovr_en = 1'b1; ovr_val = 16'hA5A5;
      access(1'b1, 1'b0, 9'h1FF, 16'h0, lat, wcyc, rd, oth);
      ovr_en = 1'b0;
      chk("p1 read data", 32'(rd), 32'hA5A5);
      chk("p1 read p0_ack", 32'(oth), 32'h0);
      chk("p1 read p0_rdata kept", 32'(bus.p0_rdata), 32'h1234);

      // Fresh reset so the first simultaneous request starts from the reset grant history.
      rst_n = 1'b0; #2 rst_n = 1'b1;
      step();

      // Simultaneous requests from idle: p0 then p1 back-to-back.
      bus.p0_we = 0; bus.p0_addr = 9'h010;
      bus.p1_we = 1; bus.p1_addr = 9'h020; bus.p1_wdata = 16'h5678;
      bus.p0_req = 1; bus.p1_req = 1;
      a0 = -1; a1 = -1;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (bus.p0_ack) begin a0 = c; bus.p0_req = 0; end
         if (bus.p1_ack) begin a1 = c; bus.p1_req = 0; end
      end
      bus.p0_req = 0; bus.p1_req = 0;
      chk("simul p0 ack cycle", 32'(a0), 32'd2);
      chk("simul p1 ack cycle", 32'(a1), 32'd3);

      // Both ports held continuously: p0 and p1 share the memory evenly.
      n0 = 0; n1 = 0;
      bus.p0_req = 1; bus.p1_req = 1;
      for (int c = 1; c <= 9; c++) begin
         step();
         n0 += int'(bus.p0_ack);
         n1 += int'(bus.p1_ack);
      end
      bus.p0_req = 0; bus.p1_req = 0;
      step(); step(); step();
      chk("held p0 acks", 32'(n0), 32'd3);
      chk("held p1 acks", 32'(n1), 32'd3);
      chk("held wrote p1 data", 32'(dm[9'h020]), 32'h5678);

      // Reset in the middle of a p0 write: the write is dropped at once.
      bus.p0_we = 1; bus.p0_addr = 9'h1AB; bus.p0_wdata = 16'hBEEF; bus.p0_req = 1;
      step();
      chk("midreset write active", 32'(bus.mem_read_write), 32'h1);
      chk("midreset addr", 32'(bus.mem_addr), 32'h1AB);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset rw dropped", 32'(bus.mem_read_write), 32'h0);
      chk("midreset busy", 32'(bus.busy), 32'h0);
      bus.p0_req = 0;
      acks = 0;
      for (int c = 0; c < 2; c++) begin
         step();
         acks += int'(bus.p0_ack);
      end
      chk("midreset no ack", 32'(acks), 32'h0);
      #2 rst_n = 1'b1;
      step();
      access(1'b1, 1'b0, 9'h1AB, 16'h0, lat, wcyc, rd, oth);
      chk("midreset word unwritten", 32'(rd), 32'h0);
      chk("post-reset latency", 32'(lat), 32'd2);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
